// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: address alignment, byte-lane enables, load extension, fault detection
// One request in flight; memory read data is sampled READ_LATENCY cycles after memAddr is presented.
module load_store_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] memAddr,
  output logic [3:0]  memWrite,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  output logic        done,
  output logic        fault,
  output logic [31:0] loadData
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        fault_q, fault_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;

  logic        req_illegal;
  logic        req_misaligned;
  logic [3:0]  byte_en;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  // Stores have no unsigned variants, so funct3[2] on a store is illegal too.
  assign req_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                       (isStore && funct3[2]);
  assign req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                          ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    byte_en = 4'b1111;
    case (funct3_q[1:0])
      2'b00:   byte_en = 4'b0001 << off_q;
      2'b01:   byte_en = 4'b0011 << off_q;
      default: byte_en = 4'b1111;
    endcase
  end

  assign rd_shift = memRData >> {off_q, 3'b000};

  always_comb begin
    rd_ext = memRData;
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = memRData;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ldata_d  = ldata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          funct3_d = funct3;
          off_d    = addr[1:0];
          addr_d   = {addr[31:2], 2'b00};
          fault_d  = req_illegal || req_misaligned;
          cnt_d    = 3'd0;
          if (isStore) wdata_d = storeData << {addr[1:0], 3'b000};
          if (req_illegal || req_misaligned) state_d = RESP;
          else if (isStore)                   state_d = WRITE;
          else                                state_d = READ;
        end
      end
      WRITE: state_d = RESP;
      READ: begin
        if (cnt_q == LAT) begin
          ldata_d = rd_ext;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      fault_q  <= 1'b0;
      cnt_q    <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      ldata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ldata_q  <= ldata_d;
    end
  end

  // Gating with rst kills a pending write enable in the same cycle reset is raised.
  assign memWrite = ((state_q == WRITE) && !rst) ? byte_en : 4'b0000;
  assign ready    = (state_q == IDLE) && !rst;
  assign done     = (state_q == RESP);
  assign fault    = (state_q == RESP) && fault_q;
  assign memAddr  = addr_q;
  assign memWData = wdata_q;
  assign loadData = ldata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - bench for load_store_unit at read latencies 0, 1 and 3
// Directed vectors, randomized requests against a reference model, and reset-abort sequences.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  logic req;
  logic isStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;

  logic [2:0]       ready_w;
  logic [2:0]       done_w;
  logic [2:0]       fault_w;
  logic [2:0][31:0] memAddr_w;
  logic [2:0][31:0] memWData_w;
  logic [2:0][31:0] memRData_w;
  logic [2:0][31:0] loadData_w;
  logic [2:0][3:0]  memWrite_w;

  logic [31:0] mem_words [0:255];

  int total = 0;
  int bad = 0;
  logic [31:0] last_ld;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [31:0] pipe [0:7];
    // Memory model: word appears L cycles after its address is presented.
    always @(posedge clk) begin
      pipe[0] <= mem_words[memAddr_w[g][9:2]];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign memRData_w[g] = (L == 0) ? mem_words[memAddr_w[g][9:2]] : pipe[(L == 0) ? 0 : L - 1];

    load_store_unit #(.READ_LATENCY(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .ready     (ready_w[g]),
      .isStore   (isStore),
      .funct3    (funct3),
      .addr      (addr),
      .storeData (storeData),
      .memAddr   (memAddr_w[g]),
      .memWrite  (memWrite_w[g]),
      .memWData  (memWData_w[g]),
      .memRData  (memRData_w[g]),
      .done      (done_w[g]),
      .fault     (fault_w[g]),
      .loadData  (loadData_w[g])
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd, input logic [31:0] prev,
                                output logic flt, output logic [3:0] we, output logic [31:0] wd,
                                output logic [31:0] ld);
    int off;
    int size;
    logic illegal;
    logic [31:0] w;
    int s;
    off = int'(a[1:0]);
    size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4);
    flt = illegal || ((off % size) != 0);
    we = 4'(((1 << size) - 1) << off);
    wd = sd << (8 * off);
    ld = prev;
    if (!st && !flt) begin
      w = rd >> (8 * off);
      if (size == 4) ld = rd;
      else if (f3[2]) ld = (size == 1) ? (w & 32'hFF) : (w & 32'hFFFF);
      else begin
        s = (size == 1) ? int'($signed(w[7:0])) : int'($signed(w[15:0]));
        ld = 32'(s);
      end
    end
  endfunction

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                        input logic [3:0] exp_we, input logic [31:0] exp_wd, input logic [31:0] exp_ld,
                        input logic exp_flt, input string tag);
    int dc;
    string p;
    chk({tag, " idle-ready"}, 32'(ready_w), 32'h7);
    req = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = sd;
    @(posedge clk); #1;
    // Garbage held on the inputs while busy must not be picked up.
    isStore = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; storeData = $urandom;
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) req = 1'b0;
      for (int g = 0; g < 3; g++) begin
        dc = exp_flt ? 1 : (st ? 2 : 2 + lat_of(g));
        p = $sformatf("%s L%0d k%0d", tag, lat_of(g), k);
        chk({p, " memWrite"}, 32'(memWrite_w[g]), (k == 1 && st && !exp_flt) ? 32'(exp_we) : 32'd0);
        if (k == 1) chk({p, " memAddr"}, memAddr_w[g], {a[31:2], 2'b00});
        if (k == 1 && st && !exp_flt) chk({p, " memWData"}, memWData_w[g], exp_wd);
        if (k < dc) begin
          chk({p, " ready-busy"}, 32'(ready_w[g]), 32'd0);
          chk({p, " done-early"}, 32'(done_w[g]), 32'd0);
        end else if (k == dc) begin
          chk({p, " done"}, 32'(done_w[g]), 32'd1);
          chk({p, " fault"}, 32'(fault_w[g]), 32'(exp_flt));
          chk({p, " loadData"}, loadData_w[g], exp_ld);
          chk({p, " memAddr-hold"}, memAddr_w[g], {a[31:2], 2'b00});
        end else begin
          chk({p, " done-late"}, 32'(done_w[g]), 32'd0);
          chk({p, " fault-late"}, 32'(fault_w[g]), 32'd0);
          chk({p, " ready-after"}, 32'(ready_w[g]), 32'd1);
          chk({p, " loadData-hold"}, loadData_w[g], exp_ld);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid(input logic st, input string tag);
    req = 1'b1; isStore = st; funct3 = 3'b010; addr = st ? 32'h300 : 32'h304; storeData = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s L%0d memWrite-in-rst", tag, lat_of(g)), 32'(memWrite_w[g]), 32'd0);
      chk($sformatf("%s L%0d ready-in-rst", tag, lat_of(g)), 32'(ready_w[g]), 32'd0);
    end
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s L%0d done-after-rst", tag, lat_of(g)), 32'(done_w[g]), 32'd0);
      chk($sformatf("%s L%0d memAddr-rst", tag, lat_of(g)), memAddr_w[g], 32'd0);
      chk($sformatf("%s L%0d loadData-rst", tag, lat_of(g)), loadData_w[g], 32'd0);
    end
    rst = 1'b0;
    #1;
    chk({tag, " ready-after-rst"}, 32'(ready_w), 32'h7);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s no-done k%0d", tag, k), 32'(done_w), 32'd0);
    end
    last_ld = 32'd0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] ld;
    logic        flt;
  } vec_t;

  vec_t vecs [13];

  initial begin
    rst = 1'b1; req = 1'b0; isStore = 1'b0; funct3 = 3'd0; addr = 32'd0; storeData = 32'd0;
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;

    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        4'b1000, 32'hA5000000, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        4'b1100, 32'h12340000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 3'b000, 32'h203, 32'h0,        32'h80F07F01, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 3'b100, 32'h203, 32'h0,        32'h80F07F01, 4'b0000, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 32'h202, 32'h0,        32'h80F07F01, 4'b0000, 32'h0,        32'hFFFF80F0, 1'b0};
    vecs[6]  = '{1'b0, 3'b101, 32'h200, 32'h0,        32'h80F07F01, 4'b0000, 32'h0,        32'h00007F01, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 32'h200, 32'h0,        32'h80F07F01, 4'b0000, 32'h0,        32'h80F07F01, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h11111111, 4'b0000, 32'h0,        32'h80F07F01, 1'b1};
    vecs[9]  = '{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        4'b0000, 32'h0,        32'h80F07F01, 1'b1};
    vecs[10] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h22222222, 4'b0000, 32'h0,        32'h80F07F01, 1'b1};
    vecs[11] = '{1'b1, 3'b100, 32'h100, 32'h000000FF, 32'h0,        4'b0000, 32'h0,        32'h80F07F01, 1'b1};
    vecs[12] = '{1'b0, 3'b110, 32'h104, 32'h0,        32'h33333333, 4'b0000, 32'h0,        32'h80F07F01, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset L%0d ready", lat_of(g)), 32'(ready_w[g]), 32'd0);
      chk($sformatf("reset L%0d memWrite", lat_of(g)), 32'(memWrite_w[g]), 32'd0);
      chk($sformatf("reset L%0d memAddr", lat_of(g)), memAddr_w[g], 32'd0);
      chk($sformatf("reset L%0d memWData", lat_of(g)), memWData_w[g], 32'd0);
      chk($sformatf("reset L%0d loadData", lat_of(g)), loadData_w[g], 32'd0);
      chk($sformatf("reset L%0d done", lat_of(g)), 32'(done_w[g]), 32'd0);
      chk($sformatf("reset L%0d fault", lat_of(g)), 32'(fault_w[g]), 32'd0);
    end
    rst = 1'b0;
    #1;

    for (int i = 0; i < 13; i++) begin
      if (!vecs[i].st) mem_words[vecs[i].a[9:2]] = vecs[i].rd;
      do_req(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, vecs[i].we, vecs[i].wd,
             vecs[i].ld, vecs[i].flt, $sformatf("vec%0d", i));
    end
    last_ld = 32'h80F07F01;

    for (int i = 0; i < 60; i++) begin
      logic st;
      logic [2:0] f3;
      logic [31:0] a, sd, rd, ld, wd;
      logic [3:0] we;
      logic flt;
      st = 1'($urandom);
      f3 = 3'($urandom);
      a = $urandom;
      sd = $urandom;
      rd = $urandom;
      mem_words[a[9:2]] = rd;
      model(st, f3, a, sd, rd, last_ld, flt, we, wd, ld);
      do_req(st, f3, a, sd, we, wd, ld, flt, $sformatf("rnd%0d", i));
      last_ld = ld;
    end

    reset_mid(1'b1, "rst-write");
    reset_mid(1'b0, "rst-read");
    mem_words[8'h41] = 32'h5A5AC3C3;
    do_req(1'b0, 3'b010, 32'h104, 32'h0, 4'b0000, 32'h0, 32'h5A5AC3C3, 1'b0, "post-rst LW");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
